// File: rtl/aes_pkg.sv
// AES-128 shared definitions: S-box, round constants, MixColumn arithmetic,
// state/word typedefs and the mode selectors for the keystream engine.
package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  word_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} fsm_t;

   localparam int MODE_OFB = 0;
   localparam int MODE_CTR = 1;

   // Forward S-box, entry 0 first.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Round constant for rounds 1..10; other indices never occur in RUN.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One MixColumns column; byte 0 of the column sits in bits 31:24.
   function automatic word_t mix_column(input word_t w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES-128 round plus the matching on-the-fly key step.
// The next round key is produced first and used immediately as AddRoundKey.
module aes_round
   import aes_pkg::*;
(
   input  state_t     state,
   input  state_t     rk,
   input  logic [7:0] rc,
   input  logic       last,
   output state_t     next_state,
   output state_t     next_rk
);

   state_t sr;
   state_t mc;
   word_t  w0, w1, w2, w3, tmp, n0, n1, n2, n3;

   // SubBytes and ShiftRows fused: output byte (row r, col c) takes input
   // byte (row r, col c+r mod 4).
   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int R   = i % 4;
      localparam int C   = i / 4;
      localparam int SRC = R + 4 * ((C + R) % 4);
      assign sr[127-8*i -: 8] = sbox(state[127-8*SRC -: 8]);
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
   end

   // Key schedule step: RotWord/SubWord/rcon on the last word, then chain.
   always_comb begin
      w0  = rk[127:96];
      w1  = rk[95:64];
      w2  = rk[63:32];
      w3  = rk[31:0];
      tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
      n0  = w0 ^ tmp;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
   end

   assign next_rk    = {n0, n1, n2, n3};
   assign next_state = (last ? sr : mc) ^ next_rk;

endmodule

// File: rtl/aes_ofb_stream.sv
// Iterative AES-128 OFB/CTR keystream engine, one round per clock.
// Chaining/counter value persists between blocks until the next load.
module aes_ofb_stream
   import aes_pkg::*;
#(
   parameter int MODE      = 0,
   parameter int CTR_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [127:0] key,
   input  logic [127:0] iv,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [127:0] out_ks,
   output logic         busy
);

   // Low CTR_WIDTH bits form the counter; a shift by 128 yields 0-1 = all ones.
   localparam state_t CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

   fsm_t       state;
   state_t     key_q, fb_q, st_q, rk_q, dat_q;
   logic [3:0] rnd_q;
   state_t     rnd_st, rnd_rk, fb_upd;

   aes_round u_round (
      .state      (st_q),
      .rk         (rk_q),
      .rc         (rcon(rnd_q)),
      .last       (rnd_q == 4'd10),
      .next_state (rnd_st),
      .next_rk    (rnd_rk)
   );

   // Next feedback value, applied on the edge that enters HOLD.
   if (MODE == MODE_CTR) begin : g_ctr
      always_comb fb_upd = (fb_q & ~CTR_MASK) | ((fb_q + 128'd1) & CTR_MASK);
   end else begin : g_ofb
      always_comb fb_upd = rnd_st;
   end

   assign in_ready = (state == S_IDLE) && !load;

   // Control FSM with registered outputs; load overrides every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         key_q     <= '0;
         fb_q      <= '0;
         st_q      <= '0;
         rk_q      <= '0;
         dat_q     <= '0;
         rnd_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ks    <= '0;
         busy      <= 1'b0;
      end else if (load) begin
         key_q     <= key;
         fb_q      <= iv;
         state     <= S_IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               st_q  <= fb_q ^ key_q;
               rk_q  <= key_q;
               dat_q <= in_data;
               rnd_q <= 4'd1;
               busy  <= 1'b1;
               state <= S_RUN;
            end
            S_RUN: begin
               st_q  <= rnd_st;
               rk_q  <= rnd_rk;
               rnd_q <= rnd_q + 4'd1;
               if (rnd_q == 4'd10) begin
                  state     <= S_HOLD;
                  out_valid <= 1'b1;
                  out_ks    <= rnd_st;
                  out_data  <= dat_q ^ rnd_st;
                  fb_q      <= fb_upd;
               end
            end
            S_HOLD: if (out_ready) begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_ofb_stream.sv
// Directed bench for the AES OFB/CTR engine: one OFB and one CTR instance,
// expected blocks queued at accept time and checked at the output transfer.
module tb_aes_ofb_stream;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] key = '0, iv = '0, in_data = '0;
   logic         out_ready = 1'b0;

   logic         o_load = 1'b0, o_in_valid = 1'b0;
   logic         o_in_ready, o_out_valid, o_busy;
   logic [127:0] o_out_data, o_out_ks;

   logic         c_load = 1'b0, c_in_valid = 1'b0;
   logic         c_in_ready, c_out_valid, c_busy;
   logic [127:0] c_out_data, c_out_ks;

   int ncmp = 0;
   int nfail = 0;

   typedef struct {
      logic [127:0] d;
      logic [127:0] ks;
      bit           chk;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   aes_ofb_stream #(.MODE(0), .CTR_WIDTH(32)) u_ofb (
      .clk(clk), .rst(rst), .load(o_load), .key(key), .iv(iv),
      .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(in_data),
      .out_valid(o_out_valid), .out_ready(out_ready),
      .out_data(o_out_data), .out_ks(o_out_ks), .busy(o_busy)
   );

   aes_ofb_stream #(.MODE(1), .CTR_WIDTH(32)) u_ctr (
      .clk(clk), .rst(rst), .load(c_load), .key(key), .iv(iv),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(in_data),
      .out_valid(c_out_valid), .out_ready(out_ready),
      .out_data(c_out_data), .out_ks(c_out_ks), .busy(c_busy)
   );

   bit           sel = 1'b0;
   logic         m_in_ready, m_out_valid, m_busy;
   logic [127:0] m_out_data, m_out_ks;

   // Selected instance's outputs.
   always_comb begin
      m_in_ready  = sel ? c_in_ready  : o_in_ready;
      m_out_valid = sel ? c_out_valid : o_out_valid;
      m_busy      = sel ? c_busy      : o_busy;
      m_out_data  = sel ? c_out_data  : o_out_data;
      m_out_ks    = sel ? c_out_ks    : o_out_ks;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input bit v);
      if (sel) c_in_valid = v; else o_in_valid = v;
   endtask

   task automatic do_load(input logic [127:0] k, input logic [127:0] v);
      @(negedge clk);
      key = k;
      iv  = v;
      if (sel) c_load = 1'b1; else o_load = 1'b1;
      @(negedge clk);
      c_load = 1'b0;
      o_load = 1'b0;
   endtask

   // Accept one block, check latency, optionally stall output, then transfer.
   task automatic run_block(input string tag, input logic [127:0] din,
                            input logic [127:0] exp_out, input bit do_chk, input int hold);
      int   n;
      exp_t e;
      logic [127:0] d0, k0;
      @(negedge clk);
      n = 0;
      while (!m_in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rdy"}, m_in_ready, 1);
      in_data = din;
      set_valid(1'b1);
      sbq.push_back('{d: exp_out, ks: exp_out ^ din, chk: do_chk});
      @(posedge clk);
      #1;
      set_valid(1'b0);
      chk({tag, "_busy"}, m_busy, 1);
      n = 1;
      while (!m_out_valid && n < 40) begin
         @(posedge clk);
         #1;
         if (!m_out_valid) n++;
      end
      // n counts posedges from accept until out_valid is seen.
      chk({tag, "_lat"}, n, 10);
      d0 = m_out_data;
      k0 = m_out_ks;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_stall_d"}, m_out_data, d0);
         chk({tag, "_stall_rdy"}, m_in_ready, 0);
         chk({tag, "_stall_v"}, m_out_valid, 1);
      end
      e = sbq.pop_front();
      if (e.chk) begin
         chk({tag, "_data"}, m_out_data, e.d);
         chk({tag, "_ks"}, m_out_ks, e.ks);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_done_v"}, m_out_valid, 0);
      chk({tag, "_done_rdy"}, m_in_ready, 1);
   endtask

   localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] IV_FIPS = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KS_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_SP    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1      = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] KS_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      int n;
      bit seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", o_in_ready, 1);
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_out_data", o_out_data, '0);
      chk("rst_out_ks", o_out_ks, '0);
      chk("rst_ctr_in_ready", c_in_ready, 1);

      // Zero key / zero IV before any load.
      sel = 1'b0;
      run_block("zero", '0, KS_ZERO, 1, 0);

      // load together with in_valid accepts nothing.
      @(negedge clk);
      key = K_FIPS; iv = IV_FIPS; in_data = '1;
      o_load = 1'b1; o_in_valid = 1'b1;
      #1;
      chk("load_in_ready", o_in_ready, 0);
      @(posedge clk);
      #1;
      o_load = 1'b0; o_in_valid = 1'b0;
      chk("load_no_accept", o_busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("load_still_idle", o_busy, 0);

      run_block("fips", '0, KS_FIPS, 1, 0);

      // SP800-38A OFB with 20 stall cycles on block 1.
      do_load(K_SP, 128'h000102030405060708090a0b0c0d0e0f);
      run_block("ofb1", P1, 128'h3b3fd92eb72dad20333449f8e83cfb4a, 1, 20);
      run_block("ofb2", P2, 128'h7789508d16918f03f53c52dac54ed825, 1, 0);

      // Abort mid-RUN with a load of the FIPS key/iv.
      @(negedge clk);
      in_data = P1; o_in_valid = 1'b1;
      @(posedge clk);
      #1;
      o_in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      key = K_FIPS; iv = IV_FIPS; o_load = 1'b1;
      @(negedge clk);
      o_load = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (o_out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", seen, 0);
      run_block("abort_fips", '0, KS_FIPS, 1, 0);

      // Reset while holding a result.
      @(negedge clk);
      in_data = '0; o_in_valid = 1'b1;
      @(posedge clk);
      #1;
      o_in_valid = 1'b0;
      n = 0;
      while (!o_out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("hold_reached", o_out_valid, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_hold_valid", o_out_valid, 0);
      chk("rst_hold_data", o_out_data, '0);
      chk("rst_hold_busy", o_busy, 0);
      @(negedge clk);
      rst = 1'b0;
      run_block("post_rst", '0, KS_ZERO, 1, 0);

      // SP800-38A CTR.
      sel = 1'b1;
      do_load(K_SP, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
      run_block("ctr1", P1, 128'h874d6191b620e3261bef6864990db6ce, 1, 0);
      run_block("ctr2", P2, 128'h9806f66b7970fdff8617187bb9fffdff, 1, 0);

      // Counter wrap: low word ffffffff -> 0, upper 96 bits untouched, so
      // block 2 encrypts the all-zero block under the zero key.
      do_load('0, 128'h000000000000000000000000ffffffff);
      run_block("wrap1", '0, '0, 0, 0);
      run_block("wrap2", '0, KS_ZERO, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
